// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions one raw push-button into clean single-clock events for the
//   countdown/display datapath. Everything runs on the system clock:
//   2-FF synchroniser -> tick-sampled debounce window -> press/release/long FSM.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   pb_in          raw button level (asynchronous to clk), 1 = pressed
//   pressed        debounced level, 1 while in PRESSED or LONG
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   long_pulse     one-cycle pulse when the hold time reaches LONG_PRESS_TICKS
//   is_long        1 while in LONG
module button_conditioner #(
    parameter int SAMPLE_DIV       = 65536,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int LONG_PRESS_TICKS = 1525
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic is_long
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    logic                        sync1_r;
    logic                        sync2_r;
    logic [DIV_W-1:0]            div_cnt_r;
    logic                        tick_s;
    logic [DEBOUNCE_SAMPLES-2:0] shift_r;
    logic [DEBOUNCE_SAMPLES-1:0] win_s;
    logic                        all1_s;
    logic                        all0_s;
    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [HOLD_W-1:0]           hold_cnt_r;
    logic [HOLD_W-1:0]           hold_cnt_nxt_s;
    logic                        press_nxt_s;
    logic                        release_nxt_s;
    logic                        long_nxt_s;
    logic                        pressed_nxt_s;
    logic                        is_long_nxt_s;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pb_in;
            sync2_r <= sync1_r;
        end
    end

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Sample prescaler: free-running 0..SAMPLE_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // win_s is the window as it looks including the sample taken this tick,
    // so the FSM decides on the same edge the sample is shifted in.
    assign win_s  = {shift_r, sync2_r};
    assign all1_s = &win_s;
    assign all0_s = ~|win_s;

    // Debounce history: only the newest DEBOUNCE_SAMPLES-1 samples are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {(DEBOUNCE_SAMPLES-1){1'b0}};
        end else if (tick_s) begin
            shift_r <= win_s[DEBOUNCE_SAMPLES-2:0];
        end else begin
            shift_r <= shift_r;
        end
    end

    // FSM state and hold counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Next-state logic; release is tested before long so it wins on a shared tick.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && all1_s) begin
                    state_nxt_s    = ST_PRESSED;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (!tick_s) begin
                    state_nxt_s = ST_PRESSED;
                end else if (all0_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_LONG;
                end else begin
                    // hold_cnt_r < HOLD_LAST here, so the increment cannot wrap
                    state_nxt_s    = ST_PRESSED;
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                // hold counter stays frozen; no repeat long event
                if (tick_s && all0_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LONG;
                end
            end
            default: begin
                // unreachable encoding: recover quietly to IDLE
                state_nxt_s    = ST_IDLE;
                hold_cnt_nxt_s = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Output decode from the transition being taken this cycle.
    always_comb begin
        press_nxt_s   = (state_r == ST_IDLE) && (state_nxt_s == ST_PRESSED);
        release_nxt_s = ((state_r == ST_PRESSED) || (state_r == ST_LONG)) &&
                        (state_nxt_s == ST_IDLE);
        long_nxt_s    = (state_r == ST_PRESSED) && (state_nxt_s == ST_LONG);
        pressed_nxt_s = (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_LONG);
        is_long_nxt_s = (state_nxt_s == ST_LONG);
    end

    // Output registers: pulses and levels line up with the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            is_long       <= 1'b0;
        end else begin
            pressed       <= pressed_nxt_s;
            press_pulse   <= press_nxt_s;
            release_pulse <= release_nxt_s;
            long_pulse    <= long_nxt_s;
            is_long       <= is_long_nxt_s;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int LP = 5;
    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_LONG    = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic pb_in = 1'b0;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic is_long;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   obs_kind [512];
    int   obs_cyc  [512];
    int   obs_n  = 0;
    int   rd     = 0;
    int   cyc    = 0;
    int   r      = 0;
    int   checks = 0;
    int   passes = 0;
    int   press_cyc = 0;

    button_conditioner #(
        .SAMPLE_DIV(SD),
        .DEBOUNCE_SAMPLES(DS),
        .LONG_PRESS_TICKS(LP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pb_in(pb_in),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .is_long(is_long)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: logs every pulse seen with the cycle it was visible in.
    always @(negedge clk) begin
        if (press_pulse === 1'b1 && obs_n < 512) begin
            obs_kind[obs_n] = K_PRESS;   obs_cyc[obs_n] = cyc; obs_n = obs_n + 1;
        end
        if (release_pulse === 1'b1 && obs_n < 512) begin
            obs_kind[obs_n] = K_RELEASE; obs_cyc[obs_n] = cyc; obs_n = obs_n + 1;
        end
        if (long_pulse === 1'b1 && obs_n < 512) begin
            obs_kind[obs_n] = K_LONG;    obs_cyc[obs_n] = cyc; obs_n = obs_n + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Tick edges fall at r+4m after reset release; a tick at edge t samples the
    // pb_in value driven in cycle t-3. Returns the first tick seeing a level set from cycle c.
    function automatic int first_tick(input int c);
        int t;
        t = c + 3;
        while (((t - r) % SD) != 0) t++;
        return t;
    endfunction

    task automatic test_reset();
        exp_t e;
        int bad;
        rst = 1'b1; pb_in = 1'b0;
        wait_clks(3);
        checks++;
        if ({pressed, press_pulse, release_pulse, long_pulse, is_long} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000",
                     {pressed, press_pulse, release_pulse, long_pulse, is_long});
        else passes++;
        rst = 1'b0; r = cyc;
        bad = 0;
        repeat (40) begin
            wait_clks(1);
            if ({pressed, press_pulse, release_pulse, long_pulse, is_long} !== 5'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL idle_quiet: %0d nonzero cycles, want 0", bad);
        else passes++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) $display("FAIL reset_event: missing, want kind %0d at %0d", e.kind, e.cyc);
            else if (obs_kind[rd] !== e.kind || obs_cyc[rd] !== e.cyc) begin
                $display("FAIL reset_event: got kind %0d at %0d, want kind %0d at %0d",
                         obs_kind[rd], obs_cyc[rd], e.kind, e.cyc);
                rd++;
            end else begin passes++; rd++; end
        end
        checks++;
        if (obs_n !== rd) $display("FAIL reset_extra: %0d unexpected events, want 0", obs_n - rd);
        else passes++;
        rd = obs_n;
    endtask

    task automatic test_bounce_press();
        exp_t e;
        int s;
        // Phase chosen so the final 3-clk low segment is actually sampled.
        while (((cyc - r) % SD) != 2) wait_clks(1);
        s = cyc;
        for (int j = 0; j < 8; j++) begin
            pb_in = ((j % 2) == 0) ? 1'b1 : 1'b0;
            wait_clks(3);
        end
        pb_in = 1'b1;
        // samples read s+27, s+31, s+35 -> third tick after the last edge is edge s+38
        press_cyc = s + 38;
        exp_q.push_back('{K_PRESS, press_cyc});
        wait_clks(press_cyc - 1 - cyc);
        checks++;
        if (pressed !== 1'b0) $display("FAIL bounce_pressed_early: got %b want 0", pressed);
        else passes++;
        wait_clks(1);
        checks++;
        if (pressed !== 1'b1) $display("FAIL bounce_pressed_level: got %b want 1", pressed);
        else passes++;
        wait_clks(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) $display("FAIL bounce_event: missing, want kind %0d at %0d", e.kind, e.cyc);
            else if (obs_kind[rd] !== e.kind || obs_cyc[rd] !== e.cyc) begin
                $display("FAIL bounce_event: got kind %0d at %0d, want kind %0d at %0d",
                         obs_kind[rd], obs_cyc[rd], e.kind, e.cyc);
                rd++;
            end else begin passes++; rd++; end
        end
        checks++;
        if (obs_n !== rd) $display("FAIL bounce_extra: %0d unexpected events, want 0", obs_n - rd);
        else passes++;
        rd = obs_n;
    endtask

    task automatic test_long_hold();
        exp_t e;
        exp_q.push_back('{K_LONG, press_cyc + LP * SD});
        wait_clks(press_cyc + LP * SD - 1 - cyc);
        checks++;
        if (is_long !== 1'b0) $display("FAIL long_early: is_long got %b want 0", is_long);
        else passes++;
        wait_clks(1);
        checks++;
        if ({pressed, is_long} !== 2'b11) $display("FAIL long_levels: got %b want 11", {pressed, is_long});
        else passes++;
        wait_clks(100);
        checks++;
        if (is_long !== 1'b1) $display("FAIL long_stays: is_long got %b want 1", is_long);
        else passes++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) $display("FAIL long_event: missing, want kind %0d at %0d", e.kind, e.cyc);
            else if (obs_kind[rd] !== e.kind || obs_cyc[rd] !== e.cyc) begin
                $display("FAIL long_event: got kind %0d at %0d, want kind %0d at %0d",
                         obs_kind[rd], obs_cyc[rd], e.kind, e.cyc);
                rd++;
            end else begin passes++; rd++; end
        end
        checks++;
        if (obs_n !== rd) $display("FAIL long_repeat: %0d unexpected events, want 0", obs_n - rd);
        else passes++;
        rd = obs_n;
    endtask

    task automatic test_release_long();
        exp_t e;
        int rel;
        pb_in = 1'b0;
        rel = first_tick(cyc) + (DS - 1) * SD;
        exp_q.push_back('{K_RELEASE, rel});
        wait_clks(rel - 1 - cyc);
        checks++;
        if (pressed !== 1'b1) $display("FAIL release_early: pressed got %b want 1", pressed);
        else passes++;
        wait_clks(1);
        checks++;
        if ({pressed, is_long} !== 2'b00) $display("FAIL release_levels: got %b want 00", {pressed, is_long});
        else passes++;
        wait_clks(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) $display("FAIL release_event: missing, want kind %0d at %0d", e.kind, e.cyc);
            else if (obs_kind[rd] !== e.kind || obs_cyc[rd] !== e.cyc) begin
                $display("FAIL release_event: got kind %0d at %0d, want kind %0d at %0d",
                         obs_kind[rd], obs_cyc[rd], e.kind, e.cyc);
                rd++;
            end else begin passes++; rd++; end
        end
        checks++;
        if (obs_n !== rd) $display("FAIL release_extra: %0d unexpected events, want 0", obs_n - rd);
        else passes++;
        rd = obs_n;
    endtask

    task automatic test_short_and_early_release();
        exp_t e;
        int p;
        // 8 clk high covers only two samples: must be filtered out.
        pb_in = 1'b1;
        wait_clks(2 * SD);
        pb_in = 1'b0;
        wait_clks(40);
        checks++;
        if (pressed !== 1'b0) $display("FAIL glitch_pressed: got %b want 0", pressed);
        else passes++;
        // Fresh press, then release timed so all0 lands on hold tick 4,
        // the very tick on which long_pulse would otherwise fire.
        pb_in = 1'b1;
        p = first_tick(cyc) + (DS - 1) * SD;
        exp_q.push_back('{K_PRESS, p});
        wait_clks(p + 9 - cyc);
        pb_in = 1'b0;
        exp_q.push_back('{K_RELEASE, p + LP * SD});
        wait_clks(p + LP * SD - cyc);
        checks++;
        if ({pressed, is_long} !== 2'b00) $display("FAIL early_rel_levels: got %b want 00", {pressed, is_long});
        else passes++;
        wait_clks(30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) $display("FAIL short_event: missing, want kind %0d at %0d", e.kind, e.cyc);
            else if (obs_kind[rd] !== e.kind || obs_cyc[rd] !== e.cyc) begin
                $display("FAIL short_event: got kind %0d at %0d, want kind %0d at %0d",
                         obs_kind[rd], obs_cyc[rd], e.kind, e.cyc);
                rd++;
            end else begin passes++; rd++; end
        end
        checks++;
        if (obs_n !== rd) $display("FAIL short_extra: %0d unexpected events, want 0", obs_n - rd);
        else passes++;
        rd = obs_n;
    endtask

    task automatic test_reset_in_long();
        exp_t e;
        int p;
        pb_in = 1'b1;
        p = first_tick(cyc) + (DS - 1) * SD;
        exp_q.push_back('{K_PRESS, p});
        exp_q.push_back('{K_LONG, p + LP * SD});
        wait_clks(p + LP * SD + 5 - cyc);
        checks++;
        if (is_long !== 1'b1) $display("FAIL pre_reset_long: is_long got %b want 1", is_long);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({pressed, press_pulse, release_pulse, long_pulse, is_long} !== 5'b0)
            $display("FAIL async_reset: got %b want 00000",
                     {pressed, press_pulse, release_pulse, long_pulse, is_long});
        else passes++;
        wait_clks(3);
        rst = 1'b0; r = cyc;
        // button still held: needs a fresh window of three 1 samples
        exp_q.push_back('{K_PRESS, first_tick(r) + (DS - 1) * SD});
        wait_clks(first_tick(r) + (DS - 1) * SD + 10 - cyc);
        checks++;
        if ({pressed, is_long} !== 2'b10) $display("FAIL post_reset_levels: got %b want 10", {pressed, is_long});
        else passes++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) $display("FAIL rst_long_event: missing, want kind %0d at %0d", e.kind, e.cyc);
            else if (obs_kind[rd] !== e.kind || obs_cyc[rd] !== e.cyc) begin
                $display("FAIL rst_long_event: got kind %0d at %0d, want kind %0d at %0d",
                         obs_kind[rd], obs_cyc[rd], e.kind, e.cyc);
                rd++;
            end else begin passes++; rd++; end
        end
        checks++;
        if (obs_n !== rd) $display("FAIL rst_long_extra: %0d unexpected events, want 0", obs_n - rd);
        else passes++;
        rd = obs_n;
    endtask

    initial begin
        test_reset();
        test_bounce_press();
        test_long_hold();
        test_release_long();
        test_short_and_early_release();
        test_reset_in_long();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
